// File: rtl/bcd_score_keeper.sv
// bcd_score_keeper: packed-BCD game score with edge-detected hit events,
// single-cycle ripple-carry decimal add, saturate/wrap overflow handling,
// and a high-score register that is committed by an end-of-game clear.
module bcd_score_keeper #(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hit,
  input  logic [3:0]            points,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   hi_score,
  output logic                  new_high,
  output logic                  overflow
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic          hit_q,      hit_d;
  logic [W-1:0]  score_q,    score_d;
  logic [W-1:0]  hi_q,       hi_d;
  logic          new_high_q, new_high_d;
  logic          overflow_q, overflow_d;

  logic          rise;
  logic [3:0]    pts;
  logic [W-1:0]  sum_bcd;
  logic [DIGITS:0] carry;

  // Clamp the per-event value to a legal BCD digit; 10-15 count as 9.
  always_comb begin
    pts = (points > 4'd9) ? 4'd9 : points;
  end

  assign carry[0] = 1'b0;

  // One decimal adder cell per digit; the carry ripples through all digits
  // combinationally so the whole add completes in one clock.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [4:0] dsum;
      logic [3:0] addend;
      assign addend = (gi == 0) ? pts : 4'd0;
      assign dsum   = {1'b0, score_q[4*gi +: 4]} + {1'b0, addend} + {4'd0, carry[gi]};
      assign carry[gi+1] = (dsum > 5'd9);
      // Max dsum is 19, so subtracting 10 in four bits always lands on 0-9.
      assign sum_bcd[4*gi +: 4] = carry[gi+1] ? (dsum[3:0] - 4'd10) : dsum[3:0];
    end
  endgenerate

  assign rise = hit & ~hit_q;

  // Next-state: clear has priority over a coincident hit edge; the high-score
  // compare uses the pre-clear score. Packed BCD with valid digits orders the
  // same as a plain unsigned compare, which equals an MSD-first digit compare.
  always_comb begin
    hit_d      = hit;
    score_d    = score_q;
    hi_d       = hi_q;
    new_high_d = 1'b0;
    overflow_d = overflow_q;
    if (clear) begin
      if (score_q > hi_q) begin
        hi_d       = score_q;
        new_high_d = 1'b1;
      end
      score_d    = '0;
      overflow_d = 1'b0;
    end else if (rise && (pts != 4'd0)) begin
      if (carry[DIGITS]) begin
        overflow_d = 1'b1;
        score_d    = SATURATE ? ALL_NINES : sum_bcd;
      end else begin
        score_d    = sum_bcd;
      end
    end
  end

  // State registers; reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_q      <= 1'b0;
      score_q    <= '0;
      hi_q       <= '0;
      new_high_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      hit_q      <= hit_d;
      score_q    <= score_d;
      hi_q       <= hi_d;
      new_high_q <= new_high_d;
      overflow_q <= overflow_d;
    end
  end

  // Outputs come straight from the registers.
  always_comb begin
    score    = score_q;
    hi_score = hi_q;
    new_high = new_high_q;
    overflow = overflow_q;
  end

endmodule

// File: tb/tb_bcd_score_keeper.sv
// Scoreboard bench for bcd_score_keeper: a saturating and a wrapping instance
// share the same stimulus; expectations are queued with the cycle they become
// valid and a negedge monitor pops and compares them.
module tb_bcd_score_keeper;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hit = 1'b0;
  logic [3:0]  points = 4'd0;
  logic        clear = 1'b0;

  logic [15:0] s_score, s_hi, w_score, w_hi;
  logic        s_nh, s_ov, w_nh, w_ov;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_cnt = 0;

  typedef struct {
    int          cyc;
    int          sel;      // 0 = saturating instance, 1 = wrapping instance
    logic [15:0] sc;
    logic [15:0] hi;
    logic        nh;
    logic        ov;
    string       name;
  } exp_t;

  exp_t sb[$];

  bcd_score_keeper #(.DIGITS(4), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .hit(hit), .points(points), .clear(clear),
    .score(s_score), .hi_score(s_hi), .new_high(s_nh), .overflow(s_ov)
  );

  bcd_score_keeper #(.DIGITS(4), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset), .hit(hit), .points(points), .clear(clear),
    .score(w_score), .hi_score(w_hi), .new_high(w_nh), .overflow(w_ov)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt++;

  task automatic compare(input exp_t e);
    logic [15:0] gsc, ghi;
    logic        gnh, gov;
    if (e.sel == 0) begin
      gsc = s_score; ghi = s_hi; gnh = s_nh; gov = s_ov;
    end else begin
      gsc = w_score; ghi = w_hi; gnh = w_nh; gov = w_ov;
    end
    n_cmp++;
    if (gsc !== e.sc || ghi !== e.hi || gnh !== e.nh || gov !== e.ov) begin
      n_bad++;
      $display("FAIL %s[%0d]: got score=%h hi=%h new_high=%b ovf=%b, required score=%h hi=%h new_high=%b ovf=%b",
               e.name, e.sel, gsc, ghi, gnh, gov, e.sc, e.hi, e.nh, e.ov);
    end else begin
      $display("chk %s[%0d] ok: score=%h hi=%h new_high=%b ovf=%b",
               e.name, e.sel, gsc, ghi, gnh, gov);
    end
  endtask

  // Monitor: compare every expectation whose cycle has arrived.
  exp_t mon_e;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      mon_e = sb.pop_front();
      compare(mon_e);
    end
  end

  task automatic do_cycle(input logic h, input logic [3:0] p, input logic c);
    @(negedge clk);
    hit = h; points = p; clear = c;
  endtask

  // Expected outputs after the next rising edge.
  task automatic expect_out(input string name, input int sel, input logic [15:0] sc,
                            input logic [15:0] hi, input logic nh, input logic ov);
    exp_t e;
    e.cyc = cyc_cnt + 1; e.sel = sel; e.sc = sc; e.hi = hi; e.nh = nh; e.ov = ov; e.name = name;
    sb.push_back(e);
  endtask

  task automatic pulse(input logic [3:0] p);
    do_cycle(1'b1, p, 1'b0);
    do_cycle(1'b0, p, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expectations still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic apply_reset();
    drain();
    @(negedge clk);
    reset = 1'b0; hit = 1'b0; points = 4'd0; clear = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    // Reset state
    repeat (2) @(negedge clk);
    e.cyc = 0; e.sc = 16'h0; e.hi = 16'h0; e.nh = 1'b0; e.ov = 1'b0; e.name = "reset_state";
    e.sel = 0; compare(e);
    e.sel = 1; compare(e);
    reset = 1'b1;

    // Ten one-cycle pulses of 1 point
    repeat (9) pulse(4'd1);
    do_cycle(1'b1, 4'd1, 1'b0);
    expect_out("ten_pulses", 0, 16'h0010, 16'h0, 1'b0, 1'b0);
    do_cycle(1'b0, 4'd1, 1'b0);

    // Hit held high for 5 cycles is one event
    do_cycle(1'b1, 4'd1, 1'b0);
    expect_out("hold_first", 0, 16'h0011, 16'h0, 1'b0, 1'b0);
    repeat (4) do_cycle(1'b1, 4'd1, 1'b0);
    do_cycle(1'b0, 4'd1, 1'b0);
    expect_out("hold_5", 0, 16'h0011, 16'h0, 1'b0, 1'b0);

    // Reach 0042, then async reset between clock edges
    repeat (3) pulse(4'd9);
    do_cycle(1'b1, 4'd4, 1'b0);
    expect_out("pre_reset_42", 0, 16'h0042, 16'h0, 1'b0, 1'b0);
    expect_out("pre_reset_42", 1, 16'h0042, 16'h0, 1'b0, 1'b0);
    do_cycle(1'b0, 4'd0, 1'b0);
    #2 reset = 1'b0;
    #1;
    e.cyc = cyc_cnt; e.sc = 16'h0; e.hi = 16'h0; e.nh = 1'b0; e.ov = 1'b0; e.name = "async_reset";
    e.sel = 0; compare(e);
    e.sel = 1; compare(e);

    // Hit already high at reset release counts once on the first edge
    @(negedge clk);
    hit = 1'b1; points = 4'd3;
    @(negedge clk);
    reset = 1'b1;
    expect_out("hit_at_release", 0, 16'h0003, 16'h0, 1'b0, 1'b0);
    do_cycle(1'b1, 4'd3, 1'b0);
    expect_out("held_after_release", 0, 16'h0003, 16'h0, 1'b0, 1'b0);
    do_cycle(1'b0, 4'd0, 1'b0);

    // Carry: 3 + 110*9 + 6 = 999, then +1 = 1000
    repeat (110) pulse(4'd9);
    do_cycle(1'b1, 4'd6, 1'b0);
    expect_out("pre_999", 0, 16'h0999, 16'h0, 1'b0, 1'b0);
    do_cycle(1'b0, 4'd6, 1'b0);
    do_cycle(1'b1, 4'd1, 1'b0);
    expect_out("carry_1000", 0, 16'h1000, 16'h0, 1'b0, 1'b0);
    expect_out("carry_1000", 1, 16'h1000, 16'h0, 1'b0, 1'b0);
    do_cycle(1'b0, 4'd1, 1'b0);

    // 0095 + 7 = 0102, then points=12 adds 9, then points=0 is a no-op
    apply_reset();
    repeat (10) pulse(4'd9);
    pulse(4'd5);
    do_cycle(1'b1, 4'd7, 1'b0);
    expect_out("carry_0102", 0, 16'h0102, 16'h0, 1'b0, 1'b0);
    do_cycle(1'b0, 4'd7, 1'b0);
    do_cycle(1'b1, 4'd12, 1'b0);
    expect_out("points12", 0, 16'h0111, 16'h0, 1'b0, 1'b0);
    do_cycle(1'b0, 4'd12, 1'b0);
    do_cycle(1'b1, 4'd0, 1'b0);
    expect_out("points0", 0, 16'h0111, 16'h0, 1'b0, 1'b0);
    do_cycle(1'b0, 4'd0, 1'b0);

    // High score: 30 committed, then 42 beats it, then 20 does not
    apply_reset();
    repeat (3) pulse(4'd9);
    pulse(4'd3);
    do_cycle(1'b0, 4'd0, 1'b1);
    expect_out("clear_30", 0, 16'h0000, 16'h0030, 1'b1, 1'b0);
    do_cycle(1'b0, 4'd0, 1'b0);
    expect_out("nh_drop_30", 0, 16'h0000, 16'h0030, 1'b0, 1'b0);
    repeat (4) pulse(4'd9);
    pulse(4'd6);
    do_cycle(1'b0, 4'd0, 1'b1);
    expect_out("clear_42", 0, 16'h0000, 16'h0042, 1'b1, 1'b0);
    do_cycle(1'b0, 4'd0, 1'b0);
    expect_out("nh_one_cycle", 0, 16'h0000, 16'h0042, 1'b0, 1'b0);
    repeat (2) pulse(4'd9);
    pulse(4'd2);
    do_cycle(1'b0, 4'd0, 1'b1);
    expect_out("clear_low", 0, 16'h0000, 16'h0042, 1'b0, 1'b0);
    do_cycle(1'b0, 4'd0, 1'b0);

    // Rise and clear together: clear wins, compare against 0015
    apply_reset();
    pulse(4'd9);
    do_cycle(1'b1, 4'd6, 1'b0);
    expect_out("pre_15", 0, 16'h0015, 16'h0, 1'b0, 1'b0);
    do_cycle(1'b0, 4'd6, 1'b0);
    do_cycle(1'b1, 4'd5, 1'b1);
    expect_out("rise_and_clear", 0, 16'h0000, 16'h0015, 1'b1, 1'b0);
    do_cycle(1'b1, 4'd5, 1'b0);
    expect_out("no_redetect", 0, 16'h0000, 16'h0015, 1'b0, 1'b0);
    do_cycle(1'b0, 4'd0, 1'b0);

    // Overflow: 9998 + 5 saturates / wraps, then +9, then clear
    apply_reset();
    repeat (1110) pulse(4'd9);
    do_cycle(1'b1, 4'd8, 1'b0);
    expect_out("pre_9998", 0, 16'h9998, 16'h0, 1'b0, 1'b0);
    expect_out("pre_9998", 1, 16'h9998, 16'h0, 1'b0, 1'b0);
    do_cycle(1'b0, 4'd8, 1'b0);
    do_cycle(1'b1, 4'd5, 1'b0);
    expect_out("ovf_add5", 0, 16'h9999, 16'h0, 1'b0, 1'b1);
    expect_out("ovf_add5", 1, 16'h0003, 16'h0, 1'b0, 1'b1);
    do_cycle(1'b0, 4'd5, 1'b0);
    do_cycle(1'b1, 4'd9, 1'b0);
    expect_out("ovf_add9", 0, 16'h9999, 16'h0, 1'b0, 1'b1);
    expect_out("sticky_add9", 1, 16'h0012, 16'h0, 1'b0, 1'b1);
    do_cycle(1'b0, 4'd9, 1'b0);
    do_cycle(1'b1, 4'd0, 1'b0);
    expect_out("sat_points0", 0, 16'h9999, 16'h0, 1'b0, 1'b1);
    do_cycle(1'b0, 4'd0, 1'b1);
    expect_out("clear_ovf", 0, 16'h0000, 16'h9999, 1'b1, 1'b0);
    expect_out("clear_ovf", 1, 16'h0000, 16'h0012, 1'b1, 1'b0);
    do_cycle(1'b0, 4'd0, 1'b0);
    expect_out("after_clear", 0, 16'h0000, 16'h9999, 1'b0, 1'b0);
    expect_out("after_clear", 1, 16'h0000, 16'h0012, 1'b0, 1'b0);

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
